// File: rtl/lvds_link_controller.sv
// 7:1 LVDS link sequencer: power-up, training, then RGB666 packing
// into three FPD-Link data lanes plus the clock lane.
module lvds_link_controller #(
  parameter int PWRUP_CYCLES = 64,
  parameter int TRAIN_WORDS  = 1024,
  parameter int UF_W         = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            pix_valid,
  output logic            pix_ready,
  input  logic [17:0]     pix_rgb,
  input  logic            pix_hs,
  input  logic            pix_vs,
  input  logic            pix_de,
  output logic [6:0]      lane0,
  output logic [6:0]      lane1,
  output logic [6:0]      lane2,
  output logic [6:0]      lane_clk,
  output logic            link_up,
  output logic [UF_W-1:0] uf_count
);

  typedef enum logic [1:0] {
    S_OFF,
    S_PWRUP,
    S_TRAIN,
    S_ACTIVE
  } state_t;

  localparam logic [6:0]  CLK_WORD   = 7'b1100011;
  localparam logic [6:0]  TRAIN_WORD = 7'b1110000;
  localparam logic [15:0] PWRUP_LD   = 16'(PWRUP_CYCLES - 1);
  localparam logic [15:0] TRAIN_LD   = 16'(TRAIN_WORDS - 1);

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [6:0]      lane0_q, lane0_d;
  logic [6:0]      lane1_q, lane1_d;
  logic [6:0]      lane2_q, lane2_d;
  logic [6:0]      lane_clk_q, lane_clk_d;
  logic            last_hs_q, last_hs_d;
  logic            last_vs_q, last_vs_d;
  logic [UF_W-1:0] uf_q, uf_d;

  logic [5:0] r, g, b;
  assign r = pix_rgb[17:12];
  assign g = pix_rgb[11:6];
  assign b = pix_rgb[5:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane0_d    = '0;
    lane1_d    = '0;
    lane2_d    = '0;
    lane_clk_d = '0;
    last_hs_d  = last_hs_q;
    last_vs_d  = last_vs_q;
    uf_d       = uf_q;
    unique case (state_q)
      S_OFF: begin
        if (en) begin
          state_d = S_PWRUP;
          cnt_d   = PWRUP_LD;
        end
      end
      S_PWRUP: begin
        lane_clk_d = CLK_WORD;
        if (cnt_q == '0) begin
          state_d = S_TRAIN;
          cnt_d   = TRAIN_LD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_TRAIN: begin
        lane_clk_d = CLK_WORD;
        lane0_d    = TRAIN_WORD;
        lane1_d    = TRAIN_WORD;
        lane2_d    = TRAIN_WORD;
        if (cnt_q == '0) begin
          state_d = S_ACTIVE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_ACTIVE: begin
        lane_clk_d = CLK_WORD;
        if (pix_valid) begin
          lane0_d   = {g[0], r};
          lane1_d   = {b[1:0], g[5:1]};
          lane2_d   = {pix_de, pix_vs, pix_hs, b[5:2]};
          last_hs_d = pix_hs;
          last_vs_d = pix_vs;
        end else begin
          lane2_d = {1'b0, last_vs_q, last_hs_q, 4'b0000};
          // a starved cycle on the disable edge is not an underflow
          if (en && uf_q != '1) begin
            uf_d = uf_q + UF_W'(1);
          end
        end
      end
      default: state_d = S_OFF;
    endcase
    if (!en && state_q != S_OFF) begin
      state_d = S_OFF;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      lane0_q    <= '0;
      lane1_q    <= '0;
      lane2_q    <= '0;
      lane_clk_q <= '0;
      last_hs_q  <= 1'b0;
      last_vs_q  <= 1'b0;
      uf_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lane0_q    <= lane0_d;
      lane1_q    <= lane1_d;
      lane2_q    <= lane2_d;
      lane_clk_q <= lane_clk_d;
      last_hs_q  <= last_hs_d;
      last_vs_q  <= last_vs_d;
      uf_q       <= uf_d;
    end
  end

  assign pix_ready = (state_q == S_ACTIVE);
  assign link_up   = (state_q == S_ACTIVE);
  assign lane0     = lane0_q;
  assign lane1     = lane1_q;
  assign lane2     = lane2_q;
  assign lane_clk  = lane_clk_q;
  assign uf_count  = uf_q;

endmodule
